// File: rtl/karatsuba_pkg.sv
// ---------------------------------------------------------------------------
// karatsuba_pkg
// Shared definitions for the Karatsuba multiplier slice:
//   state_t     - controller states, in the order a normal operation visits them
//   LAT_NORMAL  - cycles from operand accept to out_valid on the full path
//   LAT_FAST    - cycles from operand accept to out_valid on the small-operand path
// ---------------------------------------------------------------------------
package karatsuba_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_MID = 3'd2,
    MUL_HI  = 3'd3,
    COMBINE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int LAT_NORMAL = 5;
  localparam int LAT_FAST   = 2;

endpackage

// File: rtl/karatsuba_mult_if.sv
// ---------------------------------------------------------------------------
// karatsuba_mult_if
// Operand/product handshake bundle for karatsuba_mult.
//   in_valid/in_ready       - operand handshake (producer -> multiplier)
//   input_1/input_2         - WIDTH-bit unsigned operands
//   out_valid/out_ready     - product handshake (multiplier -> consumer)
//   product                 - 2*WIDTH-bit unsigned product
//   out_fast                - product came from the small-operand path
// Modports: master = the side supplying operands and taking products,
//           slave  = the multiplier itself.
// ---------------------------------------------------------------------------
interface karatsuba_mult_if #(
  parameter int WIDTH = 64
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     input_1;
  logic [WIDTH-1:0]     input_2;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 out_fast;

  modport master (
    output in_valid, input_1, input_2, out_ready,
    input  in_ready, out_valid, product, out_fast
  );

  modport slave (
    input  in_valid, input_1, input_2, out_ready,
    output in_ready, out_valid, product, out_fast
  );

endinterface

// File: rtl/karatsuba_submul.sv
// ---------------------------------------------------------------------------
// karatsuba_submul
// Single shared sub-multiplier used for all three Karatsuba partial products.
// Inputs are combinational; the product is registered, so a pair presented
// during one cycle is available on p during the next cycle.
//   clk_in    - clock
//   rst_n_in  - asynchronous active-low reset, clears p
//   a, b      - W-bit unsigned operands
//   p         - 2*W-bit registered product
// ---------------------------------------------------------------------------
module karatsuba_submul #(
  parameter int W = 33
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  // One multiply per cycle, result registered for a latency of exactly one.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      p <= '0;
    end else begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/karatsuba_mult.sv
// ---------------------------------------------------------------------------
// karatsuba_mult
// Sequential Karatsuba multiplier: WIDTH x WIDTH unsigned -> 2*WIDTH product
// using one shared (H+1)x(H+1) sub-multiplier, H = WIDTH/2.
//   z0 = lo1*lo2, z1 = (lo1+hi1)*(lo2+hi2), z2 = hi1*hi2
//   product = (z2 << 2H) + ((z1 - z2 - z0) << H) + z0
// When FAST_PATH is set and both upper halves are zero, only z0 is needed and
// the result is returned three cycles earlier with out_fast set.
// Ports:
//   clk_in    - clock, all state changes on its rising edge
//   rst_n_in  - asynchronous active-low reset, aborts any operation
//   bus       - karatsuba_mult_if slave: operand and product handshakes
// Parameters:
//   WIDTH     - operand width, even and at least 4
//   FAST_PATH - 1 enables the small-operand shortcut
// ---------------------------------------------------------------------------
module karatsuba_mult #(
  parameter int WIDTH     = 64,
  parameter int FAST_PATH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  karatsuba_mult_if.slave  bus
);

  import karatsuba_pkg::*;

  localparam int H  = WIDTH / 2;
  localparam int S  = H + 1;
  localparam int PW = 2 * WIDTH;

  state_t           state;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic             fast_q;
  logic [2*H-1:0]   z0_q;
  logic [2*S-1:0]   z1_q;
  logic [2*H-1:0]   z2_q;

  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_fast_q;
  logic [PW-1:0]    product_q;

  logic [S-1:0]     sub_a;
  logic [S-1:0]     sub_b;
  logic [2*S-1:0]   sub_p;
  logic [2*S-1:0]   mid;
  logic [PW-1:0]    combined;
  logic             accept;
  logic             take_fast;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_fast  = out_fast_q;
  assign bus.product   = product_q;

  assign accept    = bus.in_valid && in_ready_q;
  assign take_fast = (FAST_PATH != 0) &&
                     (bus.input_1[WIDTH-1:H] == '0) &&
                     (bus.input_2[WIDTH-1:H] == '0);

  // The sub-multiplier is fed one step ahead of the state that captures its
  // result: while IDLE it already multiplies the low halves straight off the
  // bus, so z0 is waiting in MUL_LO the cycle after accept. MUL_LO then feeds
  // the half-sums (captured in MUL_MID) and MUL_MID feeds the high halves
  // (captured in MUL_HI).
  always_comb begin
    sub_a = '0;
    sub_b = '0;
    case (state)
      IDLE: begin
        sub_a = {1'b0, bus.input_1[H-1:0]};
        sub_b = {1'b0, bus.input_2[H-1:0]};
      end
      MUL_LO: begin
        sub_a = {1'b0, op1_q[WIDTH-1:H]} + {1'b0, op1_q[H-1:0]};
        sub_b = {1'b0, op2_q[WIDTH-1:H]} + {1'b0, op2_q[H-1:0]};
      end
      MUL_MID: begin
        sub_a = {1'b0, op1_q[WIDTH-1:H]};
        sub_b = {1'b0, op2_q[WIDTH-1:H]};
      end
      default: begin
        sub_a = '0;
        sub_b = '0;
      end
    endcase
  end

  karatsuba_submul #(
    .W (S)
  ) u_submul (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .a        (sub_a),
    .b        (sub_b),
    .p        (sub_p)
  );

  // z1 >= z0 + z2 always, so the middle term never goes negative and fits in
  // 2H+2 bits. z0 occupies exactly the low 2H bits, so z2<<2H + z0 is a plain
  // concatenation and only one adder is needed.
  assign mid      = z1_q - {2'b00, z2_q} - {2'b00, z0_q};
  assign combined = {z2_q, z0_q} + ({{(PW-2*S){1'b0}}, mid} << H);

  // Controller and all registered outputs. in_ready is only ever high in
  // IDLE; it comes up one edge after reset and one edge after each output
  // handshake, which guarantees a gap cycle between products.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      fast_q      <= 1'b0;
      z0_q        <= '0;
      z1_q        <= '0;
      z2_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_fast_q  <= 1'b0;
      product_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            op1_q      <= bus.input_1;
            op2_q      <= bus.input_2;
            fast_q     <= take_fast;
            in_ready_q <= 1'b0;
            state      <= MUL_LO;
          end
        end
        MUL_LO: begin
          if (fast_q) begin
            product_q   <= {{(PW-2*S){1'b0}}, sub_p};
            out_fast_q  <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            z0_q  <= sub_p[2*H-1:0];
            state <= MUL_MID;
          end
        end
        MUL_MID: begin
          z1_q  <= sub_p;
          state <= MUL_HI;
        end
        MUL_HI: begin
          z2_q  <= sub_p[2*H-1:0];
          state <= COMBINE;
        end
        COMBINE: begin
          product_q   <= combined;
          out_fast_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_mult.sv
// ---------------------------------------------------------------------------
// tb_karatsuba_mult
// Four multipliers share one clock and reset:
//   sel 0: WIDTH 8,  FAST_PATH 1     sel 1: WIDTH 8,  FAST_PATH 0
//   sel 2: WIDTH 16, FAST_PATH 1     sel 3: WIDTH 64, FAST_PATH 1
// Expected results come from plain 128-bit multiplication and the
// small-operand rule (both upper halves zero and shortcut enabled).
// ---------------------------------------------------------------------------
module tb_karatsuba_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  karatsuba_mult_if #(.WIDTH(8))  if8f ();
  karatsuba_mult_if #(.WIDTH(8))  if8s ();
  karatsuba_mult_if #(.WIDTH(16)) if16 ();
  karatsuba_mult_if #(.WIDTH(64)) if64 ();

  karatsuba_mult #(.WIDTH(8),  .FAST_PATH(1)) u8f  (.clk_in(clk), .rst_n_in(rst_n), .bus(if8f));
  karatsuba_mult #(.WIDTH(8),  .FAST_PATH(0)) u8s  (.clk_in(clk), .rst_n_in(rst_n), .bus(if8s));
  karatsuba_mult #(.WIDTH(16), .FAST_PATH(1)) u16  (.clk_in(clk), .rst_n_in(rst_n), .bus(if16));
  karatsuba_mult #(.WIDTH(64), .FAST_PATH(1)) u64  (.clk_in(clk), .rst_n_in(rst_n), .bus(if64));

  typedef struct {
    int           sel;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] p;
    logic         f;
    int           lat;
  } vec_t;

  vec_t dir_vecs [7];

  function automatic int width_of(input int sel);
    case (sel)
      0, 1:    return 8;
      2:       return 16;
      default: return 64;
    endcase
  endfunction

  function automatic bit fast_en(input int sel);
    return (sel != 1);
  endfunction

  function automatic logic [127:0] get_product(input int sel);
    case (sel)
      0:       return {120'b0, if8f.product} | 128'b0 | {112'b0, if8f.product};
      1:       return {112'b0, if8s.product};
      2:       return {96'b0, if16.product};
      default: return if64.product;
    endcase
  endfunction

  function automatic logic get_valid(input int sel);
    case (sel)
      0:       return if8f.out_valid;
      1:       return if8s.out_valid;
      2:       return if16.out_valid;
      default: return if64.out_valid;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return if8f.in_ready;
      1:       return if8s.in_ready;
      2:       return if16.in_ready;
      default: return if64.in_ready;
    endcase
  endfunction

  function automatic logic get_fast(input int sel);
    case (sel)
      0:       return if8f.out_fast;
      1:       return if8s.out_fast;
      2:       return if16.out_fast;
      default: return if64.out_fast;
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [63:0] a, input logic [63:0] b);
    case (sel)
      0:       begin if8f.in_valid = v; if8f.input_1 = a[7:0];  if8f.input_2 = b[7:0];  end
      1:       begin if8s.in_valid = v; if8s.input_1 = a[7:0];  if8s.input_2 = b[7:0];  end
      2:       begin if16.in_valid = v; if16.input_1 = a[15:0]; if16.input_2 = b[15:0]; end
      default: begin if64.in_valid = v; if64.input_1 = a;       if64.input_2 = b;       end
    endcase
  endtask

  task automatic set_ready(input int sel, input logic r);
    case (sel)
      0:       if8f.out_ready = r;
      1:       if8s.out_ready = r;
      2:       if16.out_ready = r;
      default: if64.out_ready = r;
    endcase
  endtask

  // Drives one operation end to end and reports what it saw. All sampling
  // happens 1 time unit after a rising edge. Returns in the cycle after the
  // output handshake. ok=0 means a bounded wait expired.
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input bit rand_ready,
                        output logic [127:0] prod, output logic fast, output int lat,
                        output bit ok, output bit held);
    int   waitc;
    logic rdy;
    ok = 1'b1; held = 1'b1; lat = 0; prod = '0; fast = 1'b0;
    rdy = 1'b0;
    set_ready(sel, rdy);
    waitc = 0;
    while (!get_ready(sel) && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    if (!get_ready(sel)) begin ok = 1'b0; return; end
    drive(sel, 1'b1, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, '0, '0);
    lat = 1;
    while (!get_valid(sel) && lat < 50) begin
      if (rand_ready) begin rdy = 1'($urandom_range(0, 1)); set_ready(sel, rdy); end
      @(posedge clk); #1; lat++;
    end
    if (!get_valid(sel)) begin ok = 1'b0; set_ready(sel, 1'b0); return; end
    prod = get_product(sel);
    fast = get_fast(sel);
    if (!rand_ready) begin rdy = 1'b1; set_ready(sel, rdy); end
    waitc = 0;
    forever begin
      logic was_rdy;
      was_rdy = rdy;
      @(posedge clk); #1;
      if (was_rdy) break;
      if (get_product(sel) !== prod || get_fast(sel) !== fast || get_valid(sel) !== 1'b1)
        held = 1'b0;
      waitc++;
      rdy = (waitc > 20) ? 1'b1 : 1'($urandom_range(0, 1));
      set_ready(sel, rdy);
    end
    set_ready(sel, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      n_compared++;
      if ({get_ready(s), get_valid(s), get_fast(s)} !== 3'b000 || get_product(s) !== 128'd0) begin
        n_mismatched++;
        $display("[TB] FAIL reset_outputs sel=%0d: got ready/valid/fast=%b%b%b product=%0h, required 000 product=0",
                 s, get_ready(s), get_valid(s), get_fast(s), get_product(s));
      end
    end
    rst_n = 1'b1;
    #1;
    n_compared++;
    if (get_ready(0) !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ready_before_edge: got %b, required 0", get_ready(0));
    end
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) begin
      n_compared++;
      if (get_ready(s) !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL ready_after_reset sel=%0d: got %b, required 1", s, get_ready(s));
      end
    end
  endtask

  task automatic test_directed();
    logic [127:0] p;
    logic         f;
    int           lat;
    bit           ok;
    bit           held;
    dir_vecs[0] = '{0, 64'hFF, 64'hFF, 128'hFE01, 1'b0, 5};
    dir_vecs[1] = '{0, 64'h0F, 64'h0D, 128'h00C3, 1'b1, 2};
    dir_vecs[2] = '{1, 64'h0F, 64'h0D, 128'h00C3, 1'b0, 5};
    dir_vecs[3] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0, 5};
    dir_vecs[4] = '{3, 64'h0, 64'h1234_5678_9ABC_DEF0, 128'h0, 1'b0, 5};
    dir_vecs[5] = '{3, 64'h0, 64'h0, 128'h0, 1'b1, 2};
    dir_vecs[6] = '{2, 64'hFFFF, 64'hFFFF, 128'hFFFE_0001, 1'b0, 5};
    for (int i = 0; i < 7; i++) begin
      run_op(dir_vecs[i].sel, dir_vecs[i].a, dir_vecs[i].b, 1'b0, p, f, lat, ok, held);
      n_compared++;
      if (!ok || p !== dir_vecs[i].p || f !== dir_vecs[i].f || lat != dir_vecs[i].lat) begin
        n_mismatched++;
        $display("[TB] FAIL directed_%0d: got ok=%0d product=%0h fast=%b latency=%0d, required product=%0h fast=%b latency=%0d",
                 i, ok, p, f, lat, dir_vecs[i].p, dir_vecs[i].f, dir_vecs[i].lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] p;
    logic         f;
    int           lat;
    int           waitc;
    bit           ok;
    bit           held;
    set_ready(0, 1'b0);
    waitc = 0;
    while (!get_ready(0) && waitc < 50) begin @(posedge clk); #1; waitc++; end
    drive(0, 1'b1, 64'h5A, 64'h3C);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0);
    waitc = 0;
    while (!get_valid(0) && waitc < 50) begin @(posedge clk); #1; waitc++; end
    n_compared++;
    if (get_valid(0) !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL bp_valid_rise: got out_valid=%b, required 1", get_valid(0));
    end
    for (int i = 0; i < 10; i++) begin
      n_compared++;
      if (get_product(0) !== 128'h1518 || get_valid(0) !== 1'b1 || get_ready(0) !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL bp_hold_%0d: got product=%0h valid=%b in_ready=%b, required product=1518 valid=1 in_ready=0",
                 i, get_product(0), get_valid(0), get_ready(0));
      end
      if (i == 3) drive(0, 1'b1, 64'h11, 64'h22);
      else        drive(0, 1'b0, '0, '0);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, '0, '0);
    set_ready(0, 1'b1);
    @(posedge clk); #1;
    set_ready(0, 1'b0);
    n_compared++;
    if (get_valid(0) !== 1'b0 || get_ready(0) !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL bp_release: got valid=%b in_ready=%b, required valid=0 in_ready=1",
               get_valid(0), get_ready(0));
    end
    run_op(0, 64'h77, 64'h99, 1'b0, p, f, lat, ok, held);
    n_compared++;
    if (!ok || p !== 128'h471F || lat != 5) begin
      n_mismatched++;
      $display("[TB] FAIL bp_next_op: got ok=%0d product=%0h latency=%0d, required product=471f latency=5",
               ok, p, lat);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] p;
    logic         f;
    int           lat;
    int           waitc;
    bit           ok;
    bit           held;
    bit           saw_valid;
    waitc = 0;
    while (!get_ready(0) && waitc < 50) begin @(posedge clk); #1; waitc++; end
    drive(0, 1'b1, 64'hAB, 64'hCD);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0);
    set_ready(0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (get_valid(0) !== 1'b0 || get_ready(0) !== 1'b0 || get_product(0) !== 128'd0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_async_clear: got valid=%b in_ready=%b product=%0h, required 0/0/0",
               get_valid(0), get_ready(0), get_product(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (get_valid(0) === 1'b1) saw_valid = 1'b1;
    end
    set_ready(0, 1'b0);
    n_compared++;
    if (saw_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_no_output: got out_valid seen=%0d, required 0", saw_valid);
    end
    run_op(0, 64'h12, 64'h34, 1'b0, p, f, lat, ok, held);
    n_compared++;
    if (!ok || p !== 128'h03A8 || f !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_next_op: got ok=%0d product=%0h fast=%b, required product=3a8 fast=0",
               ok, p, f);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] p;
    logic [127:0] exp_p;
    logic         f;
    logic         exp_f;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [63:0]  mask;
    logic [63:0]  lo_mask;
    int           lat;
    int           exp_lat;
    int           n;
    int           w;
    int           mode;
    bit           ok;
    bit           held;
    for (int sel = 0; sel < 4; sel++) begin
      n = (sel == 1) ? 200 : 1000;
      w = width_of(sel);
      mask    = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      lo_mask = (64'd1 << (w / 2)) - 64'd1;
      for (int i = 0; i < n; i++) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        mode = $urandom_range(0, 7);
        if (mode == 0) a = '0;
        if (mode == 1) b = '1;
        if (mode == 2 || mode == 3) begin a = a & lo_mask; b = b & lo_mask; end
        a = a & mask;
        b = b & mask;
        exp_p   = {64'd0, a} * {64'd0, b};
        exp_f   = fast_en(sel) && ((a & ~lo_mask) == 64'd0) && ((b & ~lo_mask) == 64'd0);
        exp_lat = exp_f ? 2 : 5;
        run_op(sel, a, b, 1'b1, p, f, lat, ok, held);
        n_compared++;
        if (!ok || p !== exp_p) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_product sel=%0d #%0d %0h*%0h: got ok=%0d product=%0h, required %0h",
                   sel, i, a, b, ok, p, exp_p);
        end
        n_compared++;
        if (f !== exp_f || lat != exp_lat) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_path sel=%0d #%0d: got fast=%b latency=%0d, required fast=%b latency=%0d",
                   sel, i, f, lat, exp_f, exp_lat);
        end
        n_compared++;
        if (held !== 1'b1 || get_ready(sel) !== 1'b1 || get_valid(sel) !== 1'b0) begin
          n_mismatched++;
          $display("[TB] FAIL b2b_handshake sel=%0d #%0d: got held=%0d in_ready=%b valid=%b, required 1/1/0",
                   sel, i, held, get_ready(sel), get_valid(sel));
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      drive(s, 1'b0, '0, '0);
      set_ready(s, 1'b0);
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/karatsuba_mult.md
KARATSUBA_MULT -- requirements
Module: karatsuba_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the operand width in bits; it must be even and at least 4.
REQ-002 SHALL have parameter FAST_PATH, default 1; when 1, the small-operand shortcut (REQ-016) is enabled.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n_in  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands present on input_1/input_2.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 input_1  input  WIDTH  unsigned multiplicand.
REQ-008 input_2  input  WIDTH  unsigned multiplier.
REQ-009 out_valid  output  1  product valid.
REQ-010 out_ready  input  1  consumer accepts product.
REQ-011 product  output  2*WIDTH  unsigned product input_1*input_2.
REQ-012 out_fast  output  1  product was produced by the fast path; qualified by out_valid.

Function
REQ-013 SHALL accept an operand pair on the cycle in which in_valid and in_ready are both high; operands SHALL be registered on that edge; in_ready SHALL be high only in state IDLE.
REQ-014 SHALL use H = WIDTH/2 and split each operand as hi = bits [WIDTH-1:H] and lo = bits [H-1:0].
REQ-015 SHALL compute z0 = lo1*lo2, z1 = (lo1+hi1)*(lo2+hi2) with (H+1)-bit sums, and z2 = hi1*hi2, and SHALL produce product = (z2<<2H) + ((z1-z2-z0)<<H) + z0. The middle term is (2H+2) bits and never negative.
REQ-015a All three sub-products SHALL be issued sequentially to a single (H+1)x(H+1) sub-multiplier that has combinational inputs and a registered output (latency 1).
REQ-016 Fast path: if FAST_PATH=1 and hi1==0 and hi2==0 at accept, only z0 SHALL be computed and product = z0, with out_fast=1.
REQ-017 FSM states SHALL be IDLE, MUL_LO, MUL_MID, MUL_HI, COMBINE, DONE.
REQ-017a Normal path: IDLE->MUL_LO->MUL_MID->MUL_HI->COMBINE->DONE.
REQ-017b Fast path: IDLE->MUL_LO->DONE.
REQ-017c DONE->IDLE on out_valid&&out_ready; DONE holds otherwise.
REQ-018 Latency: with accept at cycle k, out_valid SHALL rise at cycle k+5 (normal path) or k+2 (fast path).
REQ-019 out_valid SHALL be high exactly in DONE; product and out_fast SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 After the output handshake at cycle j, in_ready SHALL be high at cycle j+1; there is no overlap of operations and there is a minimum one idle cycle between products.
REQ-021 in_valid while not in IDLE SHALL be ignored with no side effects; out_ready while out_valid=0 SHALL be ignored.
REQ-022 Operands of zero or all-ones SHALL give exact results; there is no overflow, because product is 2*WIDTH bits.

Reset
REQ-023 rst_n_in low SHALL asynchronously force state IDLE, in_ready=0, out_valid=0, out_fast=0, product=0, and clear the operand and partial-product registers.
REQ-024 in_ready SHALL go high on the first rising edge after rst_n_in deasserts.
REQ-025 Reset asserted mid-operation SHALL abort it; no out_valid SHALL appear for the aborted pair.

Structure
REQ-026 The FSM state enum (REQ-017) and the latency constants LAT_NORMAL=5 and LAT_FAST=2 SHALL live in the shared package karatsuba_pkg.
REQ-027 The sub-multiplier SHALL be the separate module karatsuba_submul, parameterised by width H+1, with clk_in, rst_n_in, and a 1-cycle registered product.
REQ-028 The combine step SHALL be registered in COMBINE and SHALL contain no multiplier.

Verification
REQ-029 WIDTH=8: input_1=0xFF, input_2=0xFF, out_ready=1 -> product=0xFE01, out_fast=0, out_valid at accept+5.
REQ-030 WIDTH=8, FAST_PATH=1: 0x0F x 0x0D -> product=0x00C3, out_fast=1, out_valid at accept+2; with FAST_PATH=0 -> same product, out_fast=0, latency 5.
REQ-031 WIDTH=64: 0xFFFFFFFFFFFFFFFF squared -> product=0xFFFFFFFFFFFFFFFE0000000000000001; 0x0 x 0x123456789ABCDEF0 -> product=0.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> product stable and in_ready=0 throughout; a new in_valid pulse during that time is ignored.
REQ-033 Assert rst_n_in low at accept+3 of 0xAB x 0xCD (WIDTH=8) -> out_valid never rises for it; the next pair 0x12 x 0x34 -> product=0x03A8.
REQ-034 1000 random back-to-back pairs for WIDTH 8, 16 and 64, with random out_ready -> every product matches a golden multiply.
